// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared encodings and helpers for the traffic light monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    SYM_OFF     = 3'd0,
    SYM_RED     = 3'd1,
    SYM_RED_YEL = 3'd2,
    SYM_GREEN   = 3'd3,
    SYM_ILLEGAL = 3'd4
  } sym_t;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  localparam logic [1:0] c_ph_off     = 2'b00;
  localparam logic [1:0] c_ph_red     = 2'b01;
  localparam logic [1:0] c_ph_red_yel = 2'b10;
  localparam logic [1:0] c_ph_green   = 2'b11;

  localparam int c_def_red_cycles = 30;
  localparam int c_def_yel_cycles = 3;
  localparam int c_def_grn_cycles = 30;
  localparam int c_def_tol        = 1;
  localparam int c_def_cnt_w      = 8;

  // Lines are ordered {red, yellow, green}.
  function automatic sym_t decode_lights(input logic [2:0] i_ryg);
    sym_t w_sym;
    case (i_ryg)
      3'b000:  w_sym = SYM_OFF;
      3'b100:  w_sym = SYM_RED;
      3'b110:  w_sym = SYM_RED_YEL;
      3'b001:  w_sym = SYM_GREEN;
      default: w_sym = SYM_ILLEGAL;
    endcase
    return w_sym;
  endfunction

  function automatic logic [1:0] phase_of(input sym_t i_sym);
    logic [1:0] w_ph;
    case (i_sym)
      SYM_RED:     w_ph = c_ph_red;
      SYM_RED_YEL: w_ph = c_ph_red_yel;
      SYM_GREEN:   w_ph = c_ph_green;
      default:     w_ph = c_ph_off;
    endcase
    return w_ph;
  endfunction

  function automatic logic is_legal_step(input sym_t i_from, input sym_t i_to);
    return ((i_from == SYM_OFF)     && (i_to == SYM_RED))     ||
           ((i_from == SYM_RED)     && (i_to == SYM_RED_YEL)) ||
           ((i_from == SYM_RED_YEL) && (i_to == SYM_GREEN))   ||
           ((i_from == SYM_GREEN)   && (i_to == SYM_RED));
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Saturating phase-duration counter with window check and
//                one-shot stuck-light timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES = c_def_red_cycles,
  parameter int YEL_CYCLES = c_def_yel_cycles,
  parameter int GRN_CYCLES = c_def_grn_cycles,
  parameter int TOL        = c_def_tol,
  parameter int CNT_W      = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_change,
  input  logic             i_locked,
  input  logic             i_legal,
  input  sym_t             i_sym,
  output logic [CNT_W-1:0] o_dur,
  output logic             o_err_time,
  output logic             o_time_viol
);

  localparam logic [CNT_W-1:0] c_dur_max = '1;
  localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_dur;
  logic             r_fired;
  logic             r_err_time;

  logic [CNT_W-1:0] w_dur_next;
  logic [31:0]      w_exp;
  logic [31:0]      w_dur_ext;
  logic [31:0]      w_next_ext;
  logic             w_checked;
  logic             w_in_window;
  logic             w_bad_exit;
  logic             w_timeout;

  always_comb begin
    w_exp     = 32'd0;
    w_checked = 1'b0;
    case (i_sym)
      SYM_RED:     begin w_exp = 32'(RED_CYCLES); w_checked = 1'b1; end
      SYM_RED_YEL: begin w_exp = 32'(YEL_CYCLES); w_checked = 1'b1; end
      SYM_GREEN:   begin w_exp = 32'(GRN_CYCLES); w_checked = 1'b1; end
      default:     begin w_exp = 32'd0;           w_checked = 1'b0; end
    endcase
  end

  always_comb begin
    w_dur_next = r_dur;
    if (i_change) begin
      w_dur_next = c_one;
    end else if (r_dur != c_dur_max) begin
      w_dur_next = r_dur + c_one;
    end
  end

  assign w_dur_ext   = 32'(r_dur);
  assign w_next_ext  = 32'(w_dur_next);
  assign w_in_window = ((w_dur_ext + 32'(TOL)) >= w_exp) &&
                       (w_dur_ext <= (w_exp + 32'(TOL)));

  // Once the timeout has fired, the eventual exit from that phase is not re-flagged.
  assign w_bad_exit  = i_change && i_locked && i_legal && w_checked &&
                       !r_fired && !w_in_window;
  assign w_timeout   = !i_change && i_locked && w_checked && !r_fired &&
                       (w_next_ext == (w_exp + 32'(TOL) + 32'd1));
  assign o_time_viol = w_bad_exit || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dur      <= '0;
      r_fired    <= 1'b0;
      r_err_time <= 1'b0;
    end else begin
      r_dur      <= w_dur_next;
      r_err_time <= o_time_viol;
      if (i_change) begin
        r_fired <= 1'b0;
      end else if (w_timeout) begin
        r_fired <= 1'b1;
      end
    end
  end

  assign o_dur      = r_dur;
  assign o_err_time = r_err_time;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_monitor
//  Description : Passive checker of light sequence, phase timing and patterns.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES = c_def_red_cycles,
  parameter int YEL_CYCLES = c_def_yel_cycles,
  parameter int GRN_CYCLES = c_def_grn_cycles,
  parameter int TOL        = c_def_tol,
  parameter int CNT_W      = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_time,
  output logic             err_seq,
  output logic             err_illegal,
  output logic [2:0]       err_flags,
  output logic [CNT_W-1:0] last_dur,
  output logic [15:0]      cycle_count
);

  sym_t             r_prev;
  lock_state_t      r_state;
  logic             r_err_seq;
  logic             r_err_illegal;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_last_dur;
  logic [15:0]      r_cycle_count;

  sym_t             w_cur;
  lock_state_t      w_state_next;
  logic             w_change;
  logic             w_legal;
  logic             w_locked;
  logic             w_seq_viol;
  logic             w_illegal_entry;
  logic             w_lock_entry;
  logic             w_cycle_done;
  logic             w_time_viol;
  logic [CNT_W-1:0] w_dur;

  assign w_cur    = decode_lights({red, yellow, green});
  assign w_change = (w_cur != r_prev);
  assign w_legal  = is_legal_step(r_prev, w_cur);
  assign w_locked = (r_state == ST_LOCKED);

  // Entering ILLEGAL is reported as err_illegal only, not also as a sequence error.
  assign w_seq_viol      = w_locked && w_change && !w_legal && (w_cur != SYM_ILLEGAL);
  assign w_illegal_entry = (w_cur == SYM_ILLEGAL) && (r_prev != SYM_ILLEGAL);
  assign w_lock_entry    = w_change && (w_cur == SYM_RED) &&
                           ((r_prev == SYM_OFF) || (r_prev == SYM_GREEN));
  assign w_cycle_done    = w_locked && w_change &&
                           (r_prev == SYM_GREEN) && (w_cur == SYM_RED);

  phase_timer #(
    .RED_CYCLES (RED_CYCLES),
    .YEL_CYCLES (YEL_CYCLES),
    .GRN_CYCLES (GRN_CYCLES),
    .TOL        (TOL),
    .CNT_W      (CNT_W)
  ) u_phase_timer (
    .clk         (clk),
    .rst         (rst),
    .i_change    (w_change),
    .i_locked    (w_locked),
    .i_legal     (w_legal),
    .i_sym       (r_prev),
    .o_dur       (w_dur),
    .o_err_time  (err_time),
    .o_time_viol (w_time_viol)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_lock_entry) begin
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if ((w_cur == SYM_ILLEGAL) || w_seq_viol) begin
          w_state_next = ST_UNLOCKED;
        end
      end
      default: w_state_next = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev        <= SYM_OFF;
      r_err_seq     <= 1'b0;
      r_err_illegal <= 1'b0;
      r_flags       <= 3'b000;
      r_last_dur    <= '0;
      r_cycle_count <= 16'd0;
    end else begin
      r_prev        <= w_cur;
      r_err_seq     <= w_seq_viol;
      r_err_illegal <= w_illegal_entry;
      r_flags       <= r_flags | {w_illegal_entry, w_seq_viol, w_time_viol};
      if (w_change) begin
        r_last_dur <= w_dur;
      end
      if (w_cycle_done) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

  assign phase       = phase_of(r_prev);
  assign locked      = (r_state == ST_LOCKED);
  assign err_seq     = r_err_seq;
  assign err_illegal = r_err_illegal;
  assign err_flags   = r_flags;
  assign last_dur    = r_last_dur;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
